// File: rtl/dbg_pkg.sv
// Shared types for the debug register reader: FSM state encoding and error codes.
package dbg_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HALT = 2'd1,
        READ      = 2'd2,
        RESP      = 2'd3
    } dbg_state_e;

    localparam logic ERR_NONE    = 1'b0;
    localparam logic ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/dbg_timeout_ctr.sv
// Halt-wait timeout counter: counts enabled cycles and flags the cycle in which
// the Cycles-th enabled cycle occurs, then restarts from zero.
module dbg_timeout_ctr #(
    parameter int Cycles = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CntW = $clog2(Cycles + 1);

    logic [CntW-1:0] cnt;

    // Expires combinationally so the FSM can leave WAIT_HALT at the same edge.
    assign expired = enable && (cnt == CntW'(Cycles - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || expired) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dbg_reg_reader.sv
// Debugger register-file reader: waits for core halt, reads one register with
// write-through bypass, returns it over a valid/ready response channel.
// Optional halt-wait timeout enabled by defining DBG_REG_READER_TIMEOUT_EN.
module dbg_reg_reader
    import dbg_pkg::*;
#(
    parameter int Width         = 32,
    parameter int AddrWidth     = 5,
    parameter int TimeoutCycles = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [AddrWidth-1:0] req_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [Width-1:0]     rsp_data,
    output logic                 rsp_err,
    input  logic                 core_halted,
    output logic                 rf_rd_en,
    output logic [AddrWidth-1:0] rf_rd_addr,
    input  logic [Width-1:0]     rf_rd_data,
    input  logic                 rf_wr_en,
    input  logic [AddrWidth-1:0] rf_wr_addr,
    input  logic [Width-1:0]     rf_wr_data
);

    dbg_state_e           state;
    dbg_state_e           state_nxt;
    logic [AddrWidth-1:0] addr_q;
    logic [Width-1:0]     data_q;
    logic                 req_fire;
    logic                 tmo_expired;

    assign req_fire   = req_valid && req_ready;
    assign req_ready  = (state == IDLE) && !rst;
    assign rsp_valid  = (state == RESP);
    assign rf_rd_en   = (state == READ);
    assign rf_rd_addr = addr_q;
    assign rsp_data   = data_q;

`ifdef DBG_REG_READER_TIMEOUT_EN
    logic err_q;

    dbg_timeout_ctr #(
        .Cycles (TimeoutCycles)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state != WAIT_HALT) || core_halted),
        .enable  ((state == WAIT_HALT) && !core_halted),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= ERR_NONE;
        end else if (state == READ) begin
            err_q <= ERR_NONE;
        end else if (tmo_expired) begin
            err_q <= ERR_TIMEOUT;
        end
    end

    assign rsp_err = err_q;
`else
    localparam int unused_timeout_cycles = TimeoutCycles;

    assign tmo_expired = 1'b0;
    assign rsp_err     = ERR_NONE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    state_nxt = core_halted ? READ : WAIT_HALT;
                end
            end
            WAIT_HALT: begin
                if (core_halted) begin
                    state_nxt = READ;
                end else if (tmo_expired) begin
                    state_nxt = RESP;
                end
            end
            READ: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A same-cycle core write to the register being read wins over the array value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (req_fire) begin
                addr_q <= req_addr;
            end
            if (state == READ) begin
                data_q <= (rf_wr_en && (rf_wr_addr == addr_q)) ? rf_wr_data : rf_rd_data;
            end else if (tmo_expired) begin
                data_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dbg_reg_reader.sv
// Bench for dbg_reg_reader: directed vector table, reset corner cases and
// randomized transactions against a cycle-timing reference model.
module tb_dbg_reg_reader;

    localparam int W   = 32;
    localparam int AW  = 5;
    localparam int TMO = 16;
`ifdef DBG_REG_READER_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;
    logic          core_halted = 1'b0;
    logic          rf_rd_en;
    logic [AW-1:0] rf_rd_addr;
    logic [W-1:0]  rf_rd_data;
    logic          rf_wr_en = 1'b0;
    logic [AW-1:0] rf_wr_addr = '0;
    logic [W-1:0]  rf_wr_data = '0;

    logic [W-1:0]  mem [32];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign rf_rd_data = mem[rf_rd_addr];

    dbg_reg_reader #(
        .Width         (W),
        .AddrWidth     (AW),
        .TimeoutCycles (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .core_halted (core_halted),
        .rf_rd_en    (rf_rd_en),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            hd;
        int            rd;
        bit            byp;
        logic [AW-1:0] wa;
        logic [W-1:0]  wd;
        logic [W-1:0]  exp_d;
        logic          exp_e;
        int            exp_lat;
        int            exp_pulses;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"},  32'(req_ready),  32'd0);
        check({tag, " rsp_valid"},  32'(rsp_valid),  32'd0);
        check({tag, " rsp_err"},    32'(rsp_err),    32'd0);
        check({tag, " rsp_data"},   rsp_data,        32'd0);
        check({tag, " rf_rd_en"},   32'(rf_rd_en),   32'd0);
        check({tag, " rf_rd_addr"}, 32'(rf_rd_addr), 32'd0);
    endtask

    // Cycle 0 is the acceptance cycle; core_halted is 0 before cycle hd and rises in cycle hd.
    task automatic run_txn(input string tag, input logic [AW-1:0] a, input int hd, input int rd,
                           input bit byp, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                           input bit rnd, input logic [W-1:0] exp_d, input logic exp_e,
                           input int exp_lat, input int exp_pulses);
        int            c;
        int            k;
        int            lat;
        int            pulses;
        int            read_c;
        bit            done;
        bit            stable;
        bit            rdy_low;
        bit            acc_ok;
        bit            after_ok;
        bit            tmo;
        logic [W-1:0]  got_d;
        logic          got_e;
        logic [W-1:0]  mdl_d;

        tmo    = TMO_ON && (hd > TMO);
        read_c = hd + 1;
        mdl_d  = '0;
        got_d  = '0;
        got_e  = 1'b0;
        lat    = -1;
        pulses = 0;
        k      = 0;
        done   = 1'b0;
        stable = 1'b1;
        rdy_low = 1'b1;

        @(negedge clk);
        acc_ok      = (req_ready === 1'b1);
        req_valid   = 1'b1;
        req_addr    = a;
        core_halted = (hd == 0);
        rsp_ready   = 1'b0;
        rf_wr_en    = 1'b0;
        c = 0;

        while (!done && c < 200) begin
            @(negedge clk);
            c++;
            if (rf_wr_en) mem[rf_wr_addr] = rf_wr_data;
            if (rf_rd_en === 1'b1) pulses++;
            if (req_ready !== 1'b0) rdy_low = 1'b0;
            rsp_ready = 1'b0;
            if (rsp_valid === 1'b1) begin
                if (lat < 0) begin
                    lat   = c;
                    got_d = rsp_data;
                    got_e = rsp_err;
                end else if (rsp_data !== got_d || rsp_err !== got_e) begin
                    stable = 1'b0;
                end
                rsp_ready = (k >= rd);
                k++;
                done = rsp_ready;
            end
            if (c < hd) core_halted = 1'b0;
            else if (c == hd || !rnd) core_halted = 1'b1;
            else core_halted = ($urandom_range(0, 1) == 1);
            req_valid = rnd && ($urandom_range(0, 1) == 1);
            req_addr  = rnd ? AW'($urandom) : a;
            if (rnd) begin
                rf_wr_en   = ($urandom_range(0, 1) == 1);
                rf_wr_addr = ($urandom_range(0, 1) == 1) ? a : AW'($urandom);
                rf_wr_data = $urandom;
            end else begin
                rf_wr_en   = byp && (c == read_c);
                rf_wr_addr = wa;
                rf_wr_data = wd;
            end
            if (c == read_c && !tmo) begin
                mdl_d = (rf_wr_en && rf_wr_addr == a) ? rf_wr_data : mem[a];
            end
        end

        @(negedge clk);
        if (rf_wr_en) mem[rf_wr_addr] = rf_wr_data;
        rf_wr_en  = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        after_ok  = (req_ready === 1'b1) && (rsp_valid === 1'b0);

        if (rnd) exp_d = tmo ? '0 : mdl_d;

        check({tag, " accept_ready"}, 32'(acc_ok),   32'd1);
        check({tag, " completed"},    32'(done),     32'd1);
        check({tag, " latency"},      32'(lat),      32'(exp_lat));
        check({tag, " rsp_data"},     got_d,         exp_d);
        check({tag, " rsp_err"},      32'(got_e),    32'(exp_e));
        check({tag, " rd_pulses"},    32'(pulses),   32'(exp_pulses));
        check({tag, " rsp_stable"},   32'(stable),   32'd1);
        check({tag, " ready_low"},    32'(rdy_low),  32'd1);
        check({tag, " back_to_back"}, 32'(after_ok), 32'd1);
    endtask

    initial begin
        bit            tmo;
        int            hd;
        bit            stray;
        logic [AW-1:0] a;

        for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[3] = 32'hDEAD_BEEF;

        vecs[0] = '{5'd3,  0,  0, 1'b0, 5'd0, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1};
        vecs[1] = '{5'd3,  0,  0, 1'b1, 5'd3, 32'h1234_5678, 32'h1234_5678, 1'b0, 2, 1};
        vecs[2] = '{5'd7,  5,  0, 1'b0, 5'd0, 32'h0,         32'hA500_0007, 1'b0, 7, 1};
        vecs[3] = '{5'd9,  0,  4, 1'b0, 5'd0, 32'h0,         32'hA500_0009, 1'b0, 2, 1};
        vecs[4] = '{5'd3,  0,  0, 1'b1, 5'd4, 32'hCAFE_F00D, 32'h1234_5678, 1'b0, 2, 1};
`ifdef DBG_REG_READER_TIMEOUT_EN
        vecs[5] = '{5'd4,  40, 1, 1'b0, 5'd0, 32'h0,         32'h0,         1'b1, 17, 0};
`else
        vecs[5] = '{5'd4,  40, 1, 1'b0, 5'd0, 32'h0,         32'hCAFE_F00D, 1'b0, 42, 1};
`endif
        vecs[6] = '{5'd31, 16, 0, 1'b0, 5'd0, 32'h0,         32'hA500_001F, 1'b0, 18, 1};

        #3;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].hd, vecs[i].rd, vecs[i].byp,
                    vecs[i].wa, vecs[i].wd, 1'b0, vecs[i].exp_d, vecs[i].exp_e,
                    vecs[i].exp_lat, vecs[i].exp_pulses);
        end

        // Reset while waiting for halt: outputs clear at once, transaction is dropped.
        @(negedge clk);
        req_valid   = 1'b1;
        req_addr    = 5'd21;
        core_halted = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst         = 1'b0;
        core_halted = 1'b1;
        stray       = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || rf_rd_en !== 1'b0) stray = 1'b1;
        end
        check("mid_rst no_response", 32'(stray), 32'd0);
        check("mid_rst idle_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 30; i++) begin
            a   = AW'($urandom);
            hd  = $urandom_range(0, 20);
            tmo = TMO_ON && (hd > TMO);
            run_txn($sformatf("rnd%0d", i), a, hd, $urandom_range(0, 3), 1'b0, '0, '0, 1'b1,
                    '0, tmo, tmo ? TMO + 1 : hd + 2, tmo ? 0 : 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
